// File: rtl/display_pkg.sv
// Shared types and constants for the display scan/pixel-output path.
// Optional feature macro: DISPLAY_TEST_PATTERN_EN (adds the x coordinate to
// the alignment stage so colour bars can be generated at the output).
package display_pkg;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Default 640x480 @ 60 Hz timing
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Colour-bar palette, left to right
  localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
  localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
  localparam rgb_t BAR_CYAN    = 24'h00FFFF;
  localparam rgb_t BAR_GREEN   = 24'h00FF00;
  localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
  localparam rgb_t BAR_RED     = 24'hFF0000;
  localparam rgb_t BAR_BLUE    = 24'h0000FF;
  localparam rgb_t BAR_BLACK   = 24'h000000;

  // One alignment-pipeline stage; sync bits are active-low, so they sit
  // in the MSBs where the idle constant below sets them high.
  typedef struct packed {
    logic   hs_n;
    logic   vs_n;
    logic   active;
`ifdef DISPLAY_TEST_PATTERN_EN
    coord_t x;
`endif
  } stage_t;

  localparam stage_t STAGE_IDLE = stage_t'({2'b11, {($bits(stage_t) - 2){1'b0}}});

  function automatic rgb_t bar_color(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Raster h/v counters, raw active/sync decode and line/frame start pulses.
// All state advances only on pix_en_i ticks.
module scan_counter
  import display_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   pix_en_i,
  output coord_t h_cnt_o,
  output coord_t v_cnt_o,
  output logic   active_o,
  output logic   hs_n_o,
  output logic   vs_n_o,
  output logic   line_start_o,
  output logic   frame_start_o
);

  localparam coord_t H_LAST   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  coord_t h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic   h_wrap_s, v_wrap_s;
  logic   line_start_q, frame_start_q;

  assign h_wrap_s = (h_cnt_q == H_LAST);
  assign v_wrap_s = (v_cnt_q == V_LAST);

  // Next raster position; v steps only when h wraps
  always_comb begin
    h_cnt_d = h_wrap_s ? '0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap_s) v_cnt_d = v_wrap_s ? '0 : v_cnt_q + 10'd1;
  end

  // Counters plus one-clk start pulses on the edge that issues h=0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= pix_en_i && h_wrap_s;
      frame_start_q <= pix_en_i && h_wrap_s && v_wrap_s;
      if (pix_en_i) begin
        h_cnt_q <= h_cnt_d;
        v_cnt_q <= v_cnt_d;
      end
    end
  end

  assign h_cnt_o       = h_cnt_q;
  assign v_cnt_o       = v_cnt_q;
  assign active_o      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_n_o        = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
  assign vs_n_o        = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/display_scan_controller.sv
// Raster scan and pixel-output stage: issues disp_x/disp_y to the background
// generator, delays active/sync by PIPE_DEPTH pixel ticks and captures the
// returned colour into the panel RGB registers.
// The colour sampled on the tick a pixel enters the last stage belongs to
// that pixel, i.e. background answers PIPE_DEPTH-1 ticks after the coordinate.
// Optional feature macro: DISPLAY_TEST_PATTERN_EN (test_mode colour bars).
module display_scan_controller
  import display_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int PIPE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_en,
  output logic [9:0]  disp_x,
  output logic [9:0]  disp_y,
  input  logic [23:0] color,
  input  logic        draw,
`ifdef DISPLAY_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_start,
  output logic        line_start
);

  coord_t h_cnt_s, v_cnt_s;
  logic   active_s, hs_n_s, vs_n_s;
  stage_t raw_s;
  stage_t stage_q [1:PIPE_DEPTH];
  logic   enter_active_s;
  rgb_t   pix_d, pix_q;
`ifdef DISPLAY_TEST_PATTERN_EN
  coord_t enter_x_s;
`endif

  scan_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_scan (
    .clk_i         (clk),
    .rst_ni        (reset_n),
    .pix_en_i      (pix_en),
    .h_cnt_o       (h_cnt_s),
    .v_cnt_o       (v_cnt_s),
    .active_o      (active_s),
    .hs_n_o        (hs_n_s),
    .vs_n_o        (vs_n_s),
    .line_start_o  (line_start),
    .frame_start_o (frame_start)
  );

  assign disp_x = h_cnt_s;
  assign disp_y = v_cnt_s;

  // Pack the raw timing of the coordinate issued this tick
  always_comb begin
    raw_s        = STAGE_IDLE;
    raw_s.active = active_s;
    raw_s.hs_n   = hs_n_s;
    raw_s.vs_n   = vs_n_s;
`ifdef DISPLAY_TEST_PATTERN_EN
    raw_s.x      = h_cnt_s;
`endif
  end

  // Stage about to enter the last pipeline slot on the next tick
  if (PIPE_DEPTH == 1) begin : g_enter_raw
    assign enter_active_s = raw_s.active;
`ifdef DISPLAY_TEST_PATTERN_EN
    assign enter_x_s      = raw_s.x;
`endif
  end else begin : g_enter_stage
    assign enter_active_s = stage_q[PIPE_DEPTH-1].active;
`ifdef DISPLAY_TEST_PATTERN_EN
    assign enter_x_s      = stage_q[PIPE_DEPTH-1].x;
`endif
  end

  // Pixel value to capture alongside the entering active bit
  always_comb begin
    pix_d = '0;
    if (enter_active_s) begin
`ifdef DISPLAY_TEST_PATTERN_EN
      if (test_mode)  pix_d = bar_color(enter_x_s[9:7]);
      else if (draw)  pix_d = color;
`else
      if (draw)       pix_d = color;
`endif
    end
  end

  // Alignment shift register and RGB capture, advancing on pix_en ticks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= PIPE_DEPTH; k++) stage_q[k] <= STAGE_IDLE;
      pix_q <= '0;
    end else if (pix_en) begin
      stage_q[1] <= raw_s;
      for (int k = 2; k <= PIPE_DEPTH; k++) stage_q[k] <= stage_q[k-1];
      pix_q <= pix_d;
    end
  end

  assign hsync   = stage_q[PIPE_DEPTH].hs_n;
  assign vsync   = stage_q[PIPE_DEPTH].vs_n;
  assign blank_n = stage_q[PIPE_DEPTH].active;
  assign red     = pix_q.r;
  assign green   = pix_q.g;
  assign blue    = pix_q.b;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller. Horizontal timing is the
// default 640-wide line; vertical timing is shrunk (10 active lines, 16
// total) so whole frames fit in a short run. PIPE_DEPTH = 2.
module tb_display_scan_controller;

  localparam int VA = 10;  // active lines in this build

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [9:0]  disp_x, disp_y;
  logic [23:0] color = '0;
  logic        draw = 1'b0;
  logic        hsync, vsync, blank_n;
  logic [7:0]  red, green, blue;
  logic        frame_start, line_start;
`ifdef DISPLAY_TEST_PATTERN_EN
  logic        test_mode = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  display_scan_controller #(
    .V_ACTIVE (VA), .V_FP (2), .V_SYNC (2), .V_BP (2), .PIPE_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pix_en      (pix_en),
    .disp_x      (disp_x),
    .disp_y      (disp_y),
    .color       (color),
    .draw        (draw),
`ifdef DISPLAY_TEST_PATTERN_EN
    .test_mode   (test_mode),
`endif
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_start (frame_start),
    .line_start  (line_start)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (x=%0d y=%0d t=%0t)",
                  tag, got, exp, disp_x, disp_y, $time);
  endtask

  // Advance one clock; leave the bench on the falling edge for sampling/driving
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_xy(input int x, input int y);
    int n;
    n = 0;
    while (!(disp_x == 10'(x) && disp_y == 10'(y)) && n < 20000) begin
      tick();
      n++;
    end
    check("reach_xy", {12'd0, disp_y, disp_x}, {12'd0, 10'(y), 10'(x)});
  endtask

  // Visible output while disp_x=k on line v shows pixel (k-2, v)
  function automatic logic exp_blank(input int k, input int v);
    return (v < VA) && (k >= 2) && (k < 642);
  endfunction

  function automatic logic exp_hs(input int k);
    return !((k >= 658) && (k < 754));
  endfunction

  initial begin
    // Reset state
    pix_en = 1'b1;
    repeat (3) tick();
    check("rst_x", disp_x, 0);
    check("rst_y", disp_y, 0);
    check("rst_hs", hsync, 1);
    check("rst_vs", vsync, 1);
    check("rst_blank", blank_n, 0);
    check("rst_rgb", {red, green, blue}, 0);
    check("rst_fs", frame_start, 0);
    check("rst_ls", line_start, 0);

    // First line with pix_en held high
    reset_n = 1'b1;
    for (int i = 1; i <= 800; i++) begin
      tick();
      check("a_x", disp_x, i % 800);
      check("a_y", disp_y, (i == 800) ? 1 : 0);
      check("a_ls", line_start, (i == 800) ? 1 : 0);
      check("a_fs", frame_start, 0);
      check("a_blank", blank_n, exp_blank(i % 800, (i == 800) ? 1 : 0));
      check("a_hs", hsync, exp_hs(i % 800));
      check("a_vs", vsync, 1);
      check("a_rgb", {red, green, blue}, 0);
    end

    // Colour capture for pixel (5,7), returned while disp_x=6
    wait_xy(6, 7);
    color = 24'h12AB34; draw = 1'b1;
    tick();
    check("cap_r", red, 8'h12);
    check("cap_g", green, 8'hAB);
    check("cap_b", blue, 8'h34);
    check("cap_blank", blank_n, 1);
    color = 24'hFFFFFF; draw = 1'b0;
    tick();
    check("nodraw_rgb", {red, green, blue}, 0);
    check("nodraw_blank", blank_n, 1);

    // Last active pixel, then the blanked tail of the line with draw held
    wait_xy(640, 7);
    color = 24'h00FF00; draw = 1'b1;
    tick();
    check("x639_rgb", {red, green, blue}, 24'h00FF00);
    check("x639_blank", blank_n, 1);
    color = 24'hFFFFFF;
    repeat (160) begin
      tick();
      check("hblank_rgb", {red, green, blue}, 0);
      check("hblank_blank", blank_n, 0);
    end
    tick();
    check("l8_rgb", {red, green, blue}, 24'hFFFFFF);
    check("l8_blank", blank_n, 1);
    draw = 1'b0; color = '0;

    // Vertical blanking and vsync alignment
    wait_xy(300, 10);
    check("vblank_blank", blank_n, 0);
    wait_xy(0, 12);
    check("vs_pre0", vsync, 1);
    tick();
    check("vs_pre1", vsync, 1);
    tick();
    check("vs_fall", vsync, 0);
    wait_xy(1, 14);
    check("vs_last", vsync, 0);
    tick();
    check("vs_rise", vsync, 1);
    wait_xy(799, 15);
    check("fs_pre", frame_start, 0);
    tick();
    check("fs_pulse", frame_start, 1);
    check("fs_ls", line_start, 1);
    check("fs_xy", {disp_y, disp_x}, 0);

    // pix_en every other clock
    pix_en = 1'b0;
    tick();
    check("fs_width", frame_start, 0);
    check("ls_width", line_start, 0);
    check("idle_x0", disp_x, 0);
    for (int j = 1; j <= 800; j++) begin
      pix_en = 1'b1;
      tick();
      check("tg_x", disp_x, j % 800);
      check("tg_ls", line_start, (j == 800) ? 1 : 0);
      check("tg_blank", blank_n, exp_blank(j % 800, 0));
      check("tg_hs", hsync, exp_hs(j % 800));
      pix_en = 1'b0;
      tick();
      check("idle_x", disp_x, j % 800);
      check("idle_ls", line_start, 0);
      check("idle_fs", frame_start, 0);
      check("idle_blank", blank_n, exp_blank(j % 800, 0));
      check("idle_hs", hsync, exp_hs(j % 800));
    end
    pix_en = 1'b1;

    // Asynchronous reset mid-frame
    color = 24'h55AA55; draw = 1'b1;
    wait_xy(300, 3);
    check("pre_rst_rgb", {red, green, blue}, 24'h55AA55);
    reset_n = 1'b0;
    #1;
    check("arst_xy", {disp_y, disp_x}, 0);
    check("arst_blank", blank_n, 0);
    check("arst_hs", hsync, 1);
    check("arst_vs", vsync, 1);
    check("arst_rgb", {red, green, blue}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1; draw = 1'b0; color = '0;
    check("rel_xy", {disp_y, disp_x}, 0);
    tick();
    check("rel_x1", disp_x, 1);
    check("rel_fs", frame_start, 0);
    check("rel_ls", line_start, 0);
    wait_xy(799, 15);
    tick();
    check("rel_fs_wrap", frame_start, 1);

`ifdef DISPLAY_TEST_PATTERN_EN
    // Colour bars ignore color/draw
    test_mode = 1'b1;
    wait_xy(2, 1);
    check("bar_white", {red, green, blue}, 24'hFFFFFF);
    wait_xy(130, 1);
    check("bar_yellow", {red, green, blue}, 24'hFFFF00);
    wait_xy(641, 1);
    check("bar_magenta", {red, green, blue}, 24'hFF00FF);
    test_mode = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Raster scan and pixel-output stage for the dashboard display, sitting directly downstream of the background generator.
- Generates the disp_x/disp_y scan coordinates that background consumes.
- Registers the returned color/draw pixel and drives the panel's red/green/blue outputs.
- Drives hsync, vsync and blank, delayed to stay aligned with the pixel pipeline.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
PIPE_DEPTH, 2, pixel-enable ticks between coordinate issue and RGB output (>=1)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
pix_en  input  1  pixel-rate enable; all state advances only when high
disp_x  output  10  current horizontal coordinate to background
disp_y  output  10  current vertical coordinate to background
color  input  24  {r[7:0],g[7:0],b[7:0]} returned by background for disp_x/disp_y
draw  input  1  background asserts when color is valid for this pixel
hsync  output  1  horizontal sync, active-low
vsync  output  1  vertical sync, active-low
blank_n  output  1  high during visible pixels, aligned with RGB
red  output  8  pixel red
green  output  8  pixel green
blue  output  8  pixel blue
frame_start  output  1  one-clk pulse on the pix_en tick where h=0, v=0 is issued
line_start  output  1  one-clk pulse on the pix_en tick where h=0 is issued

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Horizontal counter h_cnt:
  - 0..H_TOTAL-1, increments on clk when pix_en=1.
  - Wraps to 0 after H_TOTAL-1.
- Vertical counter v_cnt:
  - Increments when h_cnt wraps; wraps to 0 after V_TOTAL-1.
  - Simultaneous h and v wrap returns to (0,0) in one tick.
- Coordinate outputs:
  - disp_x = h_cnt, disp_y = v_cnt (registered, 0 latency from counter).
  - Values beyond the active region are still driven; background must tolerate them.
- Raw timing signals, per tick:
  - active_raw = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
  - hs_raw low while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw low while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
- Alignment pipeline:
  - active_raw, hs_raw and vs_raw pass through a PIPE_DEPTH-stage shift register clocked by pix_en.
  - hsync, vsync and blank_n come from the last stage.
- Pixel capture:
  - On the pix_en tick where the delayed active bit enters the last stage, RGB is loaded from color if draw=1, else 0x000000.
  - When the delayed active bit is 0, RGB is forced to 0.
- Output timing:
  - RGB, blank_n, hsync and vsync all change only on pix_en ticks.
  - Values hold between ticks.
- frame_start/line_start:
  - Registered pulses, exactly one clk wide, asserted on the clk edge that issues h_cnt=0 (and v_cnt=0 for frame_start).
- pix_en low indefinitely: everything freezes, no pulses.
- Reset (async assert, sync release):
  - h_cnt = v_cnt = 0; disp_x = disp_y = 0.
  - hsync = vsync = 1; blank_n = 0; RGB = 0.
  - frame_start = line_start = 0.
  - Pipeline stages cleared to inactive/deasserted sync.
  - Reset mid-frame restarts at (0,0). The first frame_start pulse occurs on the first pix_en tick after the wrap back to (0,0), not on release.

Optional Feature:
DISPLAY_TEST_PATTERN_EN
- Defined:
  - Adds input test_mode (1 bit).
  - When test_mode=1, the captured pixel ignores color/draw and uses eight vertical color bars.
  - Bar index = x_delayed[9:7] (white, yellow, cyan, green, magenta, red, blue, black; 0xFF/0x00 per channel).
  - The delayed x travels in the alignment pipeline.
- Undefined: no test_mode port, no x pipeline; behaviour exactly as above.

Decomposition:
- Package display_pkg holds:
  - rgb_t (packed struct r,g,b, 8 bits each) and coord_t (logic [9:0]).
  - Default 640x480 timing localparams.
  - Test-bar color constants.
- One sub-module, scan_counter: h/v counters, raw sync/active decode, start pulses.
- The top level holds the alignment pipeline and RGB capture.

Test Plan:
- Reset release, pix_en=1 constant -> disp_x counts 0..799; line_start pulses every 800 clks; frame_start every 420000 clks.
- Check hsync with PIPE_DEPTH=2 -> hsync low for exactly 96 ticks, falling 2 ticks after disp_x=656; vsync low for 2 lines starting 2 ticks after disp_y=490, h=0.
- Drive color=0x12AB34, draw=1 at disp_x=5, disp_y=7 -> red=0x12, green=0xAB, blue=0x34, blank_n=1 exactly 2 ticks later; draw=0 -> RGB=0.
- Drive color=0xFFFFFF with draw=1 during h_cnt=640..799 -> RGB stays 0 and blank_n=0 on the delayed ticks.
- pix_en toggling 1-of-2 clks -> counters advance every other clk; outputs stable on idle clks; pulses still one clk wide.
- Assert reset_n low at (300,200) for 3 clks -> outputs go to reset values immediately (async); after release, counting resumes from (0,0).
- With DISPLAY_TEST_PATTERN_EN, test_mode=1 -> x=0..127 gives 0xFFFFFF, x=128 gives 0xFFFF00, x=896-range N/A, x=639 gives 0xFF00FF.
